mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sequences a single unified memory port shared between the instruction-fetch stage and the data-memory stage of the multi-cycle processor. It accepts one request at a time from either requester and drives the memory for a fixed access latency. It returns read data with a one-cycle done pulse. Grants alternate when both requesters contend, and new grants are suppressed while the processor is halted.

Parameters:
MEM_LAT, 1, memory access cycles per transaction (>=1)
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
halt  in  1  when high, no new grant is issued
f_req  in  1  fetch read request; held until f_done
f_addr  in  AW  fetch address; stable while f_req
f_done  out  1  one-cycle pulse: fetch complete
f_rdata  out  DW  fetch read data, valid with f_done and held until next fetch done
d_req  in  1  data request; held until d_done
d_addr  in  AW  data address
d_wdata  in  DW  data write value
d_rd  in  1  data read
d_wr  in  1  data write
d_done  out  1  one-cycle pulse: data access complete
d_rdata  out  DW  data read data, valid with d_done
d_err  out  1  pulses with d_done for an illegal data op
mem_en  out  1  memory enable
mem_wr  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, combinational from mem_addr while mem_en and !mem_wr
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (any state, including mid-access):
  - State goes to IDLE and the latency counter to 0.
  - All outputs go to 0; last_grant is set to FETCH.
  - An aborted write never asserts mem_wr after the reset edge.
- State IDLE:
  - If halt, or neither requester is asserting, stay in IDLE.
  - If only one requester asserts, grant it.
  - If both assert, grant the requester opposite last_grant. After reset this means data wins.
  - On grant: latch the address, wdata, and op into internal registers; set owner and last_grant.
- Illegal data op:
  - An illegal op is d_rd==d_wr at grant.
  - The arbiter goes directly to RESP with the err flag set and read data 0.
  - No mem_en is asserted.
- Legal grant: go to ACCESS with the counter set to 0.
- State ACCESS, MEM_LAT cycles:
  - mem_en=1; mem_addr and mem_wdata come from the latched registers.
  - mem_wr=1 only on the final cycle (counter==MEM_LAT-1) and only for a write.
  - On the final cycle, capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged). Then go to RESP.
- State RESP, 1 cycle:
  - The owner's done=1 (d_err=err flag for data).
  - Memory outputs are 0. Next state is IDLE.
- Latency: a request sampled in IDLE at cycle T is followed by ACCESS in cycles T+1..T+MEM_LAT and done in cycle T+MEM_LAT+1. The minimum gap between consecutive grants is 1 IDLE cycle.
- Requester rule: the requester deasserts req on the edge ending the done cycle. A req still high in IDLE is treated as a new request.
- halt:
  - A halt asserted during ACCESS or RESP does not abort the transaction; it completes normally.
  - While halt stays high, IDLE issues no grant.
- Requester inputs are ignored outside IDLE; the latched copies are used.

Test Plan:
- Reset, then f_req=1 with f_addr=0x0010 and memory[0x0010]=0xABCD, MEM_LAT=1 -> f_done at cycle T+2 with f_rdata=0xABCD; mem_wr stays 0.
- d_req with d_wr=1, d_addr=0x0020, d_wdata=0x1234, then a d_rd of 0x0020 -> mem_wr is high exactly 1 cycle; the read returns d_rdata=0x1234 with d_err=0.
- f_req and d_req are asserted together three times in a row -> grants go data, fetch, data; each done pulse lasts exactly one cycle.
- d_req with d_rd=1 and d_wr=1 -> mem_en stays 0; d_done and d_err are 1 in the cycle after grant; d_rdata=0.
- halt=1 with both req high -> no grant and busy=0; halt raised during ACCESS with MEM_LAT=3 -> that access still completes at T+4, and no further grant follows.
- rst asserted on the final ACCESS cycle of a write -> the next cycle has all outputs 0 and state IDLE, and the memory location is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time, with alternating grants under contention and halt gating.
//
// state  | meaning
// IDLE   | waiting for a request; grants when not halted
// ACCESS | memory enabled for MEM_LAT cycles from the latched request
// RESP   | one-cycle done pulse to the owner; memory idle
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_rd,
  input  logic          d_wr,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_d;
  logic          last_d;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic pick_d;
  logic legal;
  logic in_access;

  // Under contention the requester that did not win last time goes first.
  assign pick_d    = d_req & (~f_req | ~last_d);
  assign legal     = d_rd ^ d_wr;
  assign in_access = (state == ACCESS);

  assign busy      = (state != IDLE);
  assign mem_en    = in_access;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;
  // Gating with rst keeps a write aborted by reset from reaching memory.
  assign mem_wr    = in_access & wr_q & (cnt == LAST) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner_d <= 1'b0;
      last_d  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f_done  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt && (f_req || d_req)) begin
            owner_d <= pick_d;
            last_d  <= pick_d;
            cnt     <= '0;
            if (pick_d) begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              wr_q    <= d_wr;
              if (legal) begin
                state <= ACCESS;
              end else begin
                state   <= RESP;
                d_done  <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end
            end else begin
              addr_q <= f_addr;
              wr_q   <= 1'b0;
              state  <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            state <= RESP;
            if (owner_d) begin
              d_done <= 1'b1;
              if (!wr_q) d_rdata <= mem_rdata;
            end else begin
              f_done  <= 1'b1;
              f_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=3,
// each with its own memory model; done pulses are scored against queued expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst     [2];
  logic        halt    [2];
  logic        f_req   [2];
  logic [15:0] f_addr  [2];
  logic        f_done  [2];
  logic [15:0] f_rdata [2];
  logic        d_req   [2];
  logic [15:0] d_addr  [2];
  logic [15:0] d_wdata [2];
  logic        d_rd    [2];
  logic        d_wr    [2];
  logic        d_done  [2];
  logic [15:0] d_rdata [2];
  logic        d_err   [2];
  logic        mem_en  [2];
  logic        mem_wr  [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        busy    [2];

  logic [15:0] mem [2][256];
  logic        pk_en;
  int          pk_k;
  logic [7:0]  pk_addr;
  logic [15:0] pk_data;

  typedef struct {
    bit          is_d;
    logic [15:0] rdata;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t exq [2][$];
  int   cyc;
  int   wrcnt [2];
  int   encnt [2];
  int   nvec;
  int   nerr;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.MEM_LAT(g == 0 ? 1 : 3), .AW(16), .DW(16)) u_dut (
      .clk(clk), .rst(rst[g]), .halt(halt[g]),
      .f_req(f_req[g]), .f_addr(f_addr[g]), .f_done(f_done[g]), .f_rdata(f_rdata[g]),
      .d_req(d_req[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rd(d_rd[g]), .d_wr(d_wr[g]), .d_done(d_done[g]), .d_rdata(d_rdata[g]),
      .d_err(d_err[g]), .mem_en(mem_en[g]), .mem_wr(mem_wr[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_en[k] && mem_wr[k]) mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
    if (pk_en) mem[pk_k][pk_addr] <= pk_data;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = '0;
      if (mem_en[k] && !mem_wr[k]) mem_rdata[k] = mem[k][mem_addr[k][7:0]];
    end
  end

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] && mem_wr[k]) wrcnt[k] = wrcnt[k] + 1;
      if (mem_en[k]) encnt[k] = encnt[k] + 1;
      if (f_done[k] || d_done[k]) begin
        nvec = nvec + 1;
        if (exq[k].size() == 0) begin
          nerr = nerr + 1;
          $display("FAIL unexpected_done dut%0d: f_done=%0d d_done=%0d at cycle %0d, required no pulse",
                   k, f_done[k], d_done[k], cyc);
        end else begin
          exp_t e;
          logic [15:0] rd;
          e  = exq[k].pop_front();
          rd = e.is_d ? d_rdata[k] : f_rdata[k];
          if (f_done[k] !== !e.is_d || d_done[k] !== e.is_d || cyc != e.cyc ||
              d_err[k] !== e.err || (e.chk_rd && rd !== e.rdata)) begin
            nerr = nerr + 1;
            $display("FAIL done_resp dut%0d: got f=%0d d=%0d cyc=%0d err=%0d rdata=%h, required f=%0d d=%0d cyc=%0d err=%0d rdata=%h",
                     k, f_done[k], d_done[k], cyc, d_err[k], rd,
                     !e.is_d, e.is_d, e.cyc, e.err, e.rdata);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nvec = nvec + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int k, input bit is_d, input logic [15:0] rdata,
                      input bit chk_rd, input bit err, input int at);
    exp_t e;
    e.is_d = is_d; e.rdata = rdata; e.chk_rd = chk_rd; e.err = err; e.cyc = at;
    exq[k].push_back(e);
  endtask

  task automatic poke(input int k, input logic [7:0] a, input logic [15:0] v);
    pk_en = 1'b1; pk_k = k; pk_addr = a; pk_data = v;
    tick(1);
    pk_en = 1'b0;
  endtask

  // Requester side: drop both requests on the edge that ends the n-th done cycle.
  task automatic release_after(input int k, input int n, input int budget);
    int seen = 0;
    int b = budget;
    while (seen < n && b > 0) begin
      @(negedge clk);
      if (f_done[k] || d_done[k]) seen++;
      b--;
    end
    @(posedge clk);
    #1;
    f_req[k] = 1'b0;
    d_req[k] = 1'b0;
    check($sformatf("done_wait_dut%0d", k), 128'(seen), 128'(n));
  endtask

  function automatic logic [127:0] outs(input int k);
    return 128'({f_done[k], d_done[k], d_err[k], busy[k], mem_en[k], mem_wr[k],
                 mem_addr[k], mem_wdata[k], f_rdata[k], d_rdata[k]});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int w0;
    int e0;
    nvec = 0; nerr = 0; pk_en = 1'b0; pk_k = 0; pk_addr = '0; pk_data = '0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; halt[k] = 1'b0; f_req[k] = 1'b0; d_req[k] = 1'b0;
      d_rd[k] = 1'b0; d_wr[k] = 1'b0; f_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      wrcnt[k] = 0; encnt[k] = 0;
    end
    poke(0, 8'h10, 16'hABCD);
    poke(1, 8'h10, 16'h0BEE);
    poke(1, 8'h30, 16'h7777);
    poke(1, 8'h40, 16'h4242);
    check("reset_outs_dut0", outs(0), '0);
    check("reset_outs_dut1", outs(1), '0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick(1);

    // data write then read back (MEM_LAT=1)
    c = cyc; w0 = wrcnt[0];
    d_addr[0] = 16'h0020; d_wdata[0] = 16'h1234; d_wr[0] = 1'b1; d_req[0] = 1'b1;
    push(0, 1'b1, 16'h0, 1'b0, 1'b0, c + 2);
    release_after(0, 1, 20);
    d_wr[0] = 1'b0;
    check("write_memwr_cycles", 128'(wrcnt[0] - w0), 128'd1);
    check("write_mem_value", 128'(mem[0][8'h20]), 128'h1234);
    c = cyc;
    d_rd[0] = 1'b1; d_req[0] = 1'b1;
    push(0, 1'b1, 16'h1234, 1'b1, 1'b0, c + 2);
    release_after(0, 1, 20);

    // single fetch (MEM_LAT=1)
    c = cyc; w0 = wrcnt[0];
    f_addr[0] = 16'h0010; f_req[0] = 1'b1;
    push(0, 1'b0, 16'hABCD, 1'b1, 1'b0, c + 2);
    release_after(0, 1, 20);
    check("fetch_no_memwr", 128'(wrcnt[0] - w0), 128'd0);

    // contention held through three grants: data, fetch, data
    c = cyc;
    d_addr[0] = 16'h0020; f_req[0] = 1'b1; d_req[0] = 1'b1;
    push(0, 1'b1, 16'h1234, 1'b1, 1'b0, c + 2);
    push(0, 1'b0, 16'hABCD, 1'b1, 1'b0, c + 5);
    push(0, 1'b1, 16'h1234, 1'b1, 1'b0, c + 8);
    release_after(0, 3, 40);
    d_rd[0] = 1'b0;
    check("fetch_rdata_held", 128'(f_rdata[0]), 128'hABCD);

    // legal read then illegal ops on MEM_LAT=3
    c = cyc;
    d_addr[1] = 16'h0040; d_rd[1] = 1'b1; d_req[1] = 1'b1;
    push(1, 1'b1, 16'h4242, 1'b1, 1'b0, c + 4);
    release_after(1, 1, 20);
    c = cyc; e0 = encnt[1];
    d_wr[1] = 1'b1; d_req[1] = 1'b1;
    push(1, 1'b1, 16'h0000, 1'b1, 1'b1, c + 1);
    release_after(1, 1, 20);
    check("illegal_rdrw_no_mem_en", 128'(encnt[1] - e0), 128'd0);
    c = cyc; e0 = encnt[1];
    d_rd[1] = 1'b0; d_wr[1] = 1'b0; d_req[1] = 1'b1;
    push(1, 1'b1, 16'h0000, 1'b1, 1'b1, c + 1);
    release_after(1, 1, 20);
    check("illegal_none_no_mem_en", 128'(encnt[1] - e0), 128'd0);

    // halt with both requesters pending: no grant
    halt[0] = 1'b1; f_req[0] = 1'b1; d_req[0] = 1'b1; d_rd[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("halt_idle_busy_%0d", i), 128'(busy[0]), 128'd0);
    end
    f_req[0] = 1'b0; d_req[0] = 1'b0; d_rd[0] = 1'b0; halt[0] = 1'b0;

    // halt raised mid-access (MEM_LAT=3) lets the access finish, then blocks
    c = cyc;
    f_addr[1] = 16'h0010; f_req[1] = 1'b1;
    push(1, 1'b0, 16'h0BEE, 1'b1, 1'b0, c + 4);
    tick(2);
    halt[1] = 1'b1; d_addr[1] = 16'h0040; d_rd[1] = 1'b1; d_req[1] = 1'b1;
    release_after(1, 1, 20);
    d_req[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("halt_after_busy_%0d", i), 128'(busy[1]), 128'd0);
    end
    d_req[1] = 1'b0; d_rd[1] = 1'b0; halt[1] = 1'b0;
    tick(1);

    // reset on the final access cycle of a write
    c = cyc;
    d_addr[1] = 16'h0030; d_wdata[1] = 16'h5555; d_wr[1] = 1'b1; d_req[1] = 1'b1;
    tick(3);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0; d_req[1] = 1'b0; d_wr[1] = 1'b0;
    check("abort_outs_zero", outs(1), '0);
    check("abort_mem_unchanged", 128'(mem[1][8'h30]), 128'h7777);
    tick(1);

    // after reset last_grant is fetch, so data wins contention first
    c = cyc;
    d_addr[1] = 16'h0040; d_rd[1] = 1'b1; f_addr[1] = 16'h0010;
    d_req[1] = 1'b1; f_req[1] = 1'b1;
    push(1, 1'b1, 16'h4242, 1'b1, 1'b0, c + 4);
    push(1, 1'b0, 16'h0BEE, 1'b1, 1'b0, c + 9);
    release_after(1, 2, 40);
    d_rd[1] = 1'b0;
    tick(3);

    check("queue_empty_dut0", 128'(exq[0].size()), 128'd0);
    check("queue_empty_dut1", 128'(exq[1].size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
